// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage valid/ready floating-point adder/subtractor with RNE rounding and exception flags.
// Define FP_ADD_SUBNORM_EN for full subnormal support; otherwise subnormals flush to signed zero.
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic [3:0]             flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;
  localparam int LW = $clog2(MW + 1) + 1;
  localparam int XW = (EXP_W + 2 > LW) ? EXP_W + 2 : LW;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en = out_ready || !out_valid;
  assign in_ready = en;

  logic sa, sb, ha, hb, a_nan, b_nan, a_inf, b_inf, swap, sx, sy, spec, spec_inv;
  logic [EXP_W-1:0] ea, eb, ex, ey, diff;
  logic [MW-1:0] ma, mb, mx, my, my_al;
  logic [2*MW-1:0] sh_v;
  logic [31:0] sh_n;
  logic [W-1:0] spec_w;

  // Stage 1 combinational: unpack, classify specials, order by magnitude, align the smaller operand
  always_comb begin
    sa = A[W-1];
    sb = B[W-1] ^ sub;
    ha = |A[W-2:MAN_W];
    hb = |B[W-2:MAN_W];
    a_nan = &A[W-2:MAN_W] && |A[MAN_W-1:0];
    b_nan = &B[W-2:MAN_W] && |B[MAN_W-1:0];
    a_inf = &A[W-2:MAN_W] && !(|A[MAN_W-1:0]);
    b_inf = &B[W-2:MAN_W] && !(|B[MAN_W-1:0]);
`ifdef FP_ADD_SUBNORM_EN
    ma = {ha, A[MAN_W-1:0], 3'b000};
    mb = {hb, B[MAN_W-1:0], 3'b000};
`else
    ma = ha ? {1'b1, A[MAN_W-1:0], 3'b000} : '0;
    mb = hb ? {1'b1, B[MAN_W-1:0], 3'b000} : '0;
`endif
    ea = ha ? A[W-2:MAN_W] : EXP_W'(1);
    eb = hb ? B[W-2:MAN_W] : EXP_W'(1);
    swap = {eb, mb} > {ea, ma};
    ex = swap ? eb : ea;
    ey = swap ? ea : eb;
    mx = swap ? mb : ma;
    my = swap ? ma : mb;
    sx = swap ? sb : sa;
    sy = swap ? sa : sb;
    diff = ex - ey;
    sh_n = (32'(diff) > 32'(MW)) ? 32'(MW) : 32'(diff);
    sh_v = {my, {MW{1'b0}}} >> sh_n;
    my_al = {sh_v[2*MW-1:MW+1], sh_v[MW] | (|sh_v[MW-1:0])};
    spec = a_nan | b_nan | a_inf | b_inf;
    spec_inv = a_inf & b_inf & (sa != sb);
    spec_w = (a_nan | b_nan | spec_inv) ? QNAN :
             a_inf ? {sa, EMAX, {MAN_W{1'b0}}} : {sb, EMAX, {MAN_W{1'b0}}};
  end

  logic s1_v, s1_spec, s1_inv, s1_sx, s1_esub;
  logic [W-1:0] s1_sw;
  logic [EXP_W-1:0] s1_e;
  logic [MW-1:0] s1_mx, s1_my;

  // Stage 1 register: aligned operands plus the special-case bypass word
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_v <= 1'b0;
      s1_spec <= 1'b0;
      s1_inv <= 1'b0;
      s1_sx <= 1'b0;
      s1_esub <= 1'b0;
      s1_sw <= '0;
      s1_e <= '0;
      s1_mx <= '0;
      s1_my <= '0;
    end else if (en) begin
      s1_v <= in_valid;
      s1_spec <= spec;
      s1_inv <= spec_inv;
      s1_sx <= sx;
      s1_esub <= sx ^ sy;
      s1_sw <= spec_w;
      s1_e <= ex;
      s1_mx <= mx;
      s1_my <= my_al;
    end
  end

  logic [MW:0] add_r;

  // Stage 2 combinational: magnitude add or subtract; the larger operand guarantees a non-negative result
  always_comb add_r = s1_esub ? {1'b0, s1_mx} - {1'b0, s1_my} : {1'b0, s1_mx} + {1'b0, s1_my};

  logic s2_v, s2_spec, s2_inv, s2_sign;
  logic [W-1:0] s2_sw;
  logic [EXP_W-1:0] s2_e;
  logic [MW:0] s2_m;

  // Stage 2 register: raw sum; an exact cancellation takes +0, a same-sign zero keeps its sign
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s2_v <= 1'b0;
      s2_spec <= 1'b0;
      s2_inv <= 1'b0;
      s2_sign <= 1'b0;
      s2_sw <= '0;
      s2_e <= '0;
      s2_m <= '0;
    end else if (en) begin
      s2_v <= s1_v;
      s2_spec <= s1_spec;
      s2_inv <= s1_inv;
      s2_sign <= (s1_esub && add_r == '0) ? 1'b0 : s1_sx;
      s2_sw <= s1_sw;
      s2_e <= s1_e;
      s2_m <= add_r;
    end
  end

  logic [XW-1:0] e, lz, sh, ne, fld;
  logic [MW-1:0] n;
  logic [MAN_W+1:0] rnd;
  logic g, r, s, inx, inc, tiny, flush, ovf, zero;
  logic [W-1:0] res_w;
  logic [3:0] res_f;

  // Stage 3 combinational: normalise, round to nearest even, then apply specials, zero, flush and overflow
  always_comb begin
    e = XW'(s2_e);
    lz = XW'(MW);
    for (int i = 0; i < MW; i++) if (s2_m[i]) lz = XW'(MW - 1 - i);
`ifdef FP_ADD_SUBNORM_EN
    sh = (lz < e) ? lz : e - XW'(1);
    flush = 1'b0;
`else
    sh = lz;
    flush = !s2_m[MW] && lz >= e;
`endif
    n = s2_m[MW] ? {s2_m[MW:2], |s2_m[1:0]} : s2_m[MW-1:0] << sh;
    ne = s2_m[MW] ? e + XW'(1) : e - sh;
    g = n[2];
    r = n[1];
    s = n[0];
    inx = g | r | s;
    inc = g & (r | s | n[3]);
    rnd = {1'b0, n[MW-1:3]} + (MAN_W+2)'(inc);
    fld = rnd[MAN_W+1] ? ne + XW'(1) : rnd[MAN_W] ? ne : '0;
    ovf = fld >= XW'(EMAX);
    tiny = !n[MW-1];
    zero = s2_m == '0;
    res_w = s2_spec ? s2_sw :
            zero ? {s2_sign, {(W-1){1'b0}}} :
            flush ? {s2_sign, {(W-1){1'b0}}} :
            ovf ? {s2_sign, EMAX, {MAN_W{1'b0}}} :
            {s2_sign, fld[EXP_W-1:0], rnd[MAN_W+1] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0]};
    res_f = s2_spec ? {s2_inv, 3'b000} :
            zero ? 4'b0000 :
            flush ? 4'b0011 :
            ovf ? 4'b0101 :
            {2'b00, tiny & inx, inx};
  end

  // Output register: holds result and flags while downstream stalls
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid <= 1'b0;
      sum <= '0;
      flags <= '0;
    end else if (en) begin
      out_valid <= s2_v;
      sum <= res_w;
      flags <= res_f;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed fp16 checks for fp_add_pipe (latency, rounding, specials, backpressure, reset)
module tb_fp_add_pipe;
  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [15:0] sum;
  logic [3:0] flags;
  int total = 0;
  int bad = 0;

  fp_add_pipe dut (
    .CLK(CLK), .RESETn(RESETn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .flags(flags)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] es, input logic [3:0] ef);
    @(negedge CLK);
    A = a; B = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1);
    @(negedge CLK);
    in_valid = 1'b0;
    chk({tag, "_v1"}, out_valid, 0);
    @(negedge CLK);
    chk({tag, "_v2"}, out_valid, 0);
    @(negedge CLK);
    chk({tag, "_v3"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_flags"}, flags, ef);
  endtask

  logic [15:0] ta [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3800, 16'hC000, 16'h4900, 16'h3C00};
  logic [15:0] tb [8] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h3800, 16'h3C00, 16'h4500, 16'h4000};
  logic        ts [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] te [8] = '{16'h4000, 16'h4400, 16'h4400, 16'h4200, 16'h3C00, 16'hBC00, 16'h4B80, 16'hBC00};

  initial begin
    int sent, got, cyc;
    logic held;
    logic [15:0] hsum;
    #1 RESETn = 1'b0;
    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_flags", flags, 0);
    @(negedge CLK);
    RESETn = 1'b1;

    run1("basic", 16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000);
    run1("tie", 16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001);
    run1("rnd_up", 16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001);
    run1("ovf", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
    run1("inv", 16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000);
    run1("inv_sub", 16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000);
    run1("nan", 16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000);
    run1("inf_fin", 16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 4'b0000);
    run1("sub_zero", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
    run1("neg_zero", 16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000);
`ifdef FP_ADD_SUBNORM_EN
    run1("subn", 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
`else
    run1("subn", 16'h0001, 16'h0001, 1'b0, 16'h0000, 4'b0000);
`endif

    sent = 0; got = 0; cyc = 0; held = 1'b0; hsum = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge CLK);
      out_ready = cyc[1];
      if (sent < 8) begin
        A = ta[sent]; B = tb[sent]; sub = ts[sent]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (held) begin
        chk("hold_v", out_valid, 1);
        chk("hold_sum", sum, hsum);
      end
      held = out_valid && !out_ready;
      hsum = sum;
      if (out_valid && out_ready) begin
        chk($sformatf("bp%0d", got), {flags, sum}, {4'b0000, te[got]});
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("bp_count", got, 8);
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_dup", out_valid, 0);
    end

    @(negedge CLK);
    A = 16'h3C00; B = 16'h4000; sub = 1'b0; in_valid = 1'b1;
    @(negedge CLK);
    A = 16'h4000; B = 16'h4000;
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("rst_pre_v", out_valid, 1);
    chk("rst_pre_sum", sum, 16'h4200);
    #1 RESETn = 1'b0;
    #1;
    chk("rst_mid_ov", out_valid, 0);
    chk("rst_mid_ir", in_ready, 1);
    chk("rst_mid_sum", sum, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      chk("rst_stale", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
